pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC loaded on leaving reset.
REQ-002 SHALL have parameter STALL_CNT_W, default 16, meaning the width of the stall-cycle counter.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning reset, synchronous and active-low.
REQ-005 SHALL have port id_rs1_i / id_rs2_i  input  `REG_BUS each  meaning the source register addresses being decoded in ID.
REQ-006 SHALL have port id_error_i  input  1  meaning the illegal-instruction flag from ID.
REQ-007 SHALL have port ex_rtltype_i  input  `RTLTYPE_BUS  meaning the RTL type of the instruction in EX.
REQ-008 SHALL have port ex_gprs_waddr_i  input  `REG_BUS  meaning the EX destination register.
REQ-009 SHALL have port ex_jump_i  input  1  meaning the EX jump is taken.
REQ-010 SHALL have port ex_jump_target_i  input  `DATA_BUS  meaning the EX jump target.
REQ-011 SHALL have port mem_busy_i  input  1  meaning the data memory is not ready.
REQ-012 SHALL have port pc_load_o  output  1  meaning PC is overwritten with pc_target_o this cycle.
REQ-013 SHALL have port pc_target_o  output  `DATA_BUS  meaning the PC load value.
REQ-014 SHALL have ports pc_stall_o, if_id_stall_o, id_ex_stall_o, ex_mem_stall_o  output  1 each  meaning the named register holds its value.
REQ-015 SHALL have ports if_id_flush_o, id_ex_flush_o  output  1 each  meaning the named register loads a bubble (rtltype ARICH, waddr `REG_X0).
REQ-016 SHALL have port halted_o  output  1  meaning the core is halted on an error.
REQ-017 SHALL have port stall_cnt_o  output  STALL_CNT_W  meaning the count of cycles with pc_stall_o high.

Function
REQ-018 SHALL implement FSM states BOOT, RUN, MEMWAIT, HALT.
REQ-019 BOOT (one cycle): pc_load_o=1, pc_target_o=RESET_PC, both flushes=1, all stalls=0; the next state SHALL be RUN.
REQ-020 Priority in RUN, highest first: mem_busy_i, then ex_jump_i, then id_error_i, then load-use; exactly one action per cycle.
REQ-021 mem_busy_i=1 in RUN or MEMWAIT: all four stalls=1, flushes=0, pc_load_o=0; the next state SHALL be MEMWAIT; when mem_busy_i=0, MEMWAIT SHALL return to RUN with no extra cycle and the jump/error/load-use decision SHALL be evaluated in that same cycle.
REQ-022 Jump: pc_load_o=1, pc_target_o=ex_jump_target_i, if_id_flush_o=1, id_ex_flush_o=1, no stalls; id_error_i in the same cycle SHALL be ignored because the instruction is being flushed.
REQ-023 Error (no busy, no jump): the next state SHALL be HALT; in the detection cycle id_ex_flush_o=1, pc_stall_o=1, if_id_stall_o=1.
REQ-024 Load-use: ex_rtltype_i==`RTLTYPE_RMEM, ex_gprs_waddr_i!=`REG_X0, and the waddr matches id_rs1_i or id_rs2_i → pc_stall_o=1, if_id_stall_o=1, id_ex_flush_o=1 for exactly that cycle; a non-load match SHALL NOT stall because the ID stage forwards from EX.
REQ-025 HALT: pc_stall_o, if_id_stall_o, id_ex_stall_o, ex_mem_stall_o all 1, halted_o=1, pc_load_o=0; HALT SHALL be left only by reset.
REQ-026 With no event in RUN, all control outputs SHALL be 0.
REQ-027 pc_target_o SHALL be 0 whenever pc_load_o=0.
REQ-028 stall_cnt_o SHALL increment on each cycle with pc_stall_o=1 and saturate at all-ones (no wrap); HALT cycles SHALL count.
REQ-029 All outputs except stall_cnt_o SHALL be combinational from state and inputs, with zero-cycle latency.

Reset
REQ-030 rst_n=0 at a clock edge SHALL force state BOOT and stall_cnt_o=0, including mid-MEMWAIT or in HALT.
REQ-031 During the rst_n=0 cycle, all stalls=0, flushes=1, pc_load_o=1, pc_target_o=RESET_PC, halted_o=0.

Verification
REQ-032 Release reset → first cycle pc_load_o=1, pc_target_o=0, flushes=1; second cycle all control outputs 0.
REQ-033 EX rtltype RMEM with waddr 5, ID rs2=5 → one cycle with pc_stall_o=1, if_id_stall_o=1, id_ex_flush_o=1; stall_cnt_o=1; same with rtltype ARICH → no stall.
REQ-034 ex_jump_i=1, target 0x100, id_error_i=1 in the same cycle → pc_load_o=1, pc_target_o=0x100, both flushes=1, halted_o remains 0 next cycle.
REQ-035 mem_busy_i high for 3 cycles during a load-use condition → 3 cycles with all stalls=1, then one load-use stall cycle; stall_cnt_o=4.
REQ-036 id_error_i=1 alone → halted_o=1 from the next cycle indefinitely; rst_n=0 one cycle → BOOT, halted_o=0.
REQ-037 STALL_CNT_W=2 with 5 consecutive stall cycles → stall_cnt_o holds 3.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if -- pipeline hazard/control bundle between the datapath stages
// and the pipeline controller.
//   ID inputs : id_rs1_i, id_rs2_i (source regs), id_error_i (illegal instr)
//   EX inputs : ex_rtltype_i, ex_gprs_waddr_i, ex_jump_i, ex_jump_target_i
//   MEM input : mem_busy_i (data memory not ready)
//   Outputs   : pc_load_o/pc_target_o, per-register stalls and flushes,
//               halted_o
// master = pipeline side (drives stage info), slave = controller side.
interface pipe_ctrl_if;
  logic [4:0]  id_rs1_i;
  logic [4:0]  id_rs2_i;
  logic        id_error_i;
  logic [2:0]  ex_rtltype_i;
  logic [4:0]  ex_gprs_waddr_i;
  logic        ex_jump_i;
  logic [31:0] ex_jump_target_i;
  logic        mem_busy_i;

  logic        pc_load_o;
  logic [31:0] pc_target_o;
  logic        pc_stall_o;
  logic        if_id_stall_o;
  logic        id_ex_stall_o;
  logic        ex_mem_stall_o;
  logic        if_id_flush_o;
  logic        id_ex_flush_o;
  logic        halted_o;

  modport master (
    output id_rs1_i, id_rs2_i, id_error_i, ex_rtltype_i, ex_gprs_waddr_i,
           ex_jump_i, ex_jump_target_i, mem_busy_i,
    input  pc_load_o, pc_target_o, pc_stall_o, if_id_stall_o, id_ex_stall_o,
           ex_mem_stall_o, if_id_flush_o, id_ex_flush_o, halted_o
  );

  modport slave (
    input  id_rs1_i, id_rs2_i, id_error_i, ex_rtltype_i, ex_gprs_waddr_i,
           ex_jump_i, ex_jump_target_i, mem_busy_i,
    output pc_load_o, pc_target_o, pc_stall_o, if_id_stall_o, id_ex_stall_o,
           ex_mem_stall_o, if_id_flush_o, id_ex_flush_o, halted_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- pipeline controller: PC load on boot/jump, load-use and
// memory-busy stalls, bubble insertion, halt on illegal instruction.
//   clk         : clock, rising edge
//   rst_n       : synchronous active-low reset
//   bus         : pipe_ctrl_if.slave (stage info in, control out)
//   stall_cnt_o : saturating count of cycles with pc_stall_o high
// All control outputs are combinational from state and inputs.
module pipe_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pipe_ctrl_if.slave             bus,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  localparam logic [2:0] RTLTYPE_RMEM = 3'd2;

  typedef enum logic [1:0] {BOOT, RUN, MEMWAIT, HALT} state_e;

  state_e                 state_q, state_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic load_use;

  assign load_use = (bus.ex_rtltype_i == RTLTYPE_RMEM) &&
                    (bus.ex_gprs_waddr_i != '0) &&
                    ((bus.ex_gprs_waddr_i == bus.id_rs1_i) ||
                     (bus.ex_gprs_waddr_i == bus.id_rs2_i));

  always_comb begin
    state_d            = state_q;
    bus.pc_load_o      = 1'b0;
    bus.pc_target_o    = '0;
    bus.pc_stall_o     = 1'b0;
    bus.if_id_stall_o  = 1'b0;
    bus.id_ex_stall_o  = 1'b0;
    bus.ex_mem_stall_o = 1'b0;
    bus.if_id_flush_o  = 1'b0;
    bus.id_ex_flush_o  = 1'b0;
    bus.halted_o       = 1'b0;

    if (!rst_n) begin
      // Reset cycle presents the same PC load/flush as BOOT.
      bus.pc_load_o     = 1'b1;
      bus.pc_target_o   = RESET_PC;
      bus.if_id_flush_o = 1'b1;
      bus.id_ex_flush_o = 1'b1;
    end else begin
      unique case (state_q)
        BOOT: begin
          bus.pc_load_o     = 1'b1;
          bus.pc_target_o   = RESET_PC;
          bus.if_id_flush_o = 1'b1;
          bus.id_ex_flush_o = 1'b1;
          state_d           = RUN;
        end
        // MEMWAIT decides exactly like RUN so release costs no extra cycle.
        RUN, MEMWAIT: begin
          if (bus.mem_busy_i) begin
            bus.pc_stall_o     = 1'b1;
            bus.if_id_stall_o  = 1'b1;
            bus.id_ex_stall_o  = 1'b1;
            bus.ex_mem_stall_o = 1'b1;
            state_d            = MEMWAIT;
          end else begin
            state_d = RUN;
            if (bus.ex_jump_i) begin
              // Error in ID is discarded: that instruction is flushed.
              bus.pc_load_o     = 1'b1;
              bus.pc_target_o   = bus.ex_jump_target_i;
              bus.if_id_flush_o = 1'b1;
              bus.id_ex_flush_o = 1'b1;
            end else if (bus.id_error_i) begin
              bus.pc_stall_o    = 1'b1;
              bus.if_id_stall_o = 1'b1;
              bus.id_ex_flush_o = 1'b1;
              state_d           = HALT;
            end else if (load_use) begin
              bus.pc_stall_o    = 1'b1;
              bus.if_id_stall_o = 1'b1;
              bus.id_ex_flush_o = 1'b1;
            end
          end
        end
        HALT: begin
          bus.pc_stall_o     = 1'b1;
          bus.if_id_stall_o  = 1'b1;
          bus.id_ex_stall_o  = 1'b1;
          bus.ex_mem_stall_o = 1'b1;
          bus.halted_o       = 1'b1;
        end
        default: state_d = BOOT;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (bus.pc_stall_o && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= BOOT;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl -- directed self-checking bench for pipe_ctrl.
// Control vector bit order: {pc_load, pc_stall, if_id_stall, id_ex_stall,
// ex_mem_stall, if_id_flush, id_ex_flush, halted}.
module tb_pipe_ctrl;

  localparam logic [2:0] ARICH = 3'd0;
  localparam logic [2:0] RMEM  = 3'd2;

  localparam logic [7:0] V_IDLE  = 8'b0000_0000;
  localparam logic [7:0] V_LOAD  = 8'b1000_0110;
  localparam logic [7:0] V_BUBL  = 8'b0110_0010;
  localparam logic [7:0] V_BUSY  = 8'b0111_1000;
  localparam logic [7:0] V_HALT  = 8'b0111_1001;

  logic        clk;
  logic        rst_n;
  logic [15:0] cnt;
  logic [1:0]  cnt2;

  int unsigned n_cmp;
  int unsigned n_err;

  pipe_ctrl_if u_if ();
  pipe_ctrl_if u_if2 ();

  assign u_if2.id_rs1_i         = u_if.id_rs1_i;
  assign u_if2.id_rs2_i         = u_if.id_rs2_i;
  assign u_if2.id_error_i       = u_if.id_error_i;
  assign u_if2.ex_rtltype_i     = u_if.ex_rtltype_i;
  assign u_if2.ex_gprs_waddr_i  = u_if.ex_gprs_waddr_i;
  assign u_if2.ex_jump_i        = u_if.ex_jump_i;
  assign u_if2.ex_jump_target_i = u_if.ex_jump_target_i;
  assign u_if2.mem_busy_i       = u_if.mem_busy_i;

  pipe_ctrl #(.RESET_PC(32'h0000_0000), .STALL_CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(u_if.slave), .stall_cnt_o(cnt)
  );

  pipe_ctrl #(.RESET_PC(32'h0000_0000), .STALL_CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bus(u_if2.slave), .stall_cnt_o(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ctl();
    return {u_if.pc_load_o, u_if.pc_stall_o, u_if.if_id_stall_o,
            u_if.id_ex_stall_o, u_if.ex_mem_stall_o, u_if.if_id_flush_o,
            u_if.id_ex_flush_o, u_if.halted_o};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    u_if.id_rs1_i         = 5'd0;
    u_if.id_rs2_i         = 5'd0;
    u_if.id_error_i       = 1'b0;
    u_if.ex_rtltype_i     = ARICH;
    u_if.ex_gprs_waddr_i  = 5'd0;
    u_if.ex_jump_i        = 1'b0;
    u_if.ex_jump_target_i = 32'd0;
    u_if.mem_busy_i       = 1'b0;
  endtask

  // Leaves the DUTs in RUN with counters at zero.
  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (ctl() !== V_LOAD || u_if.pc_target_o !== 32'd0) begin
      n_err++;
      $display("FAIL rst_ctl: got %b/%h want %b/%h", ctl(), u_if.pc_target_o, V_LOAD, 32'd0);
    end
    step();
    n_cmp++;
    if (cnt !== 16'd0) begin
      n_err++;
      $display("FAIL rst_cnt: got %0d want 0", cnt);
    end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (ctl() !== V_LOAD || u_if.pc_target_o !== 32'd0) begin
      n_err++;
      $display("FAIL boot_ctl: got %b/%h want %b/%h", ctl(), u_if.pc_target_o, V_LOAD, 32'd0);
    end
    step();
    n_cmp++;
    if (ctl() !== V_IDLE || u_if.pc_target_o !== 32'd0) begin
      n_err++;
      $display("FAIL run_idle: got %b/%h want %b/0", ctl(), u_if.pc_target_o, V_IDLE);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    u_if.ex_rtltype_i    = RMEM;
    u_if.ex_gprs_waddr_i = 5'd5;
    u_if.id_rs2_i        = 5'd5;
    #1;
    n_cmp++;
    if (ctl() !== V_BUBL) begin
      n_err++;
      $display("FAIL lu_rs2: got %b want %b", ctl(), V_BUBL);
    end
    step();
    u_if.ex_rtltype_i = ARICH;
    #1;
    n_cmp++;
    if (ctl() !== V_IDLE) begin
      n_err++;
      $display("FAIL lu_arich: got %b want %b", ctl(), V_IDLE);
    end
    n_cmp++;
    if (cnt !== 16'd1) begin
      n_err++;
      $display("FAIL lu_cnt: got %0d want 1", cnt);
    end
    u_if.ex_rtltype_i = RMEM;
    u_if.id_rs2_i     = 5'd0;
    u_if.id_rs1_i     = 5'd5;
    #1;
    n_cmp++;
    if (ctl() !== V_BUBL) begin
      n_err++;
      $display("FAIL lu_rs1: got %b want %b", ctl(), V_BUBL);
    end
    step();
    u_if.ex_gprs_waddr_i = 5'd0;
    u_if.id_rs1_i        = 5'd0;
    #1;
    n_cmp++;
    if (ctl() !== V_IDLE) begin
      n_err++;
      $display("FAIL lu_x0: got %b want %b", ctl(), V_IDLE);
    end
    n_cmp++;
    if (cnt !== 16'd2) begin
      n_err++;
      $display("FAIL lu_cnt2: got %0d want 2", cnt);
    end
    idle_inputs();
  endtask

  task automatic test_jump_error();
    do_reset();
    u_if.ex_jump_i        = 1'b1;
    u_if.ex_jump_target_i = 32'h0000_0100;
    u_if.id_error_i       = 1'b1;
    #1;
    n_cmp++;
    if (ctl() !== V_LOAD || u_if.pc_target_o !== 32'h100) begin
      n_err++;
      $display("FAIL jmp_ctl: got %b/%h want %b/%h", ctl(), u_if.pc_target_o, V_LOAD, 32'h100);
    end
    step();
    idle_inputs();
    #1;
    n_cmp++;
    if (ctl() !== V_IDLE || u_if.pc_target_o !== 32'd0) begin
      n_err++;
      $display("FAIL jmp_after: got %b/%h want %b/0", ctl(), u_if.pc_target_o, V_IDLE);
    end
  endtask

  task automatic test_priority();
    do_reset();
    u_if.mem_busy_i       = 1'b1;
    u_if.ex_jump_i        = 1'b1;
    u_if.ex_jump_target_i = 32'h0000_0200;
    u_if.id_error_i       = 1'b1;
    #1;
    n_cmp++;
    if (ctl() !== V_BUSY || u_if.pc_target_o !== 32'd0) begin
      n_err++;
      $display("FAIL pri_busy: got %b/%h want %b/0", ctl(), u_if.pc_target_o, V_BUSY);
    end
    step();
    u_if.mem_busy_i = 1'b0;
    u_if.id_error_i = 1'b0;
    #1;
    n_cmp++;
    if (ctl() !== V_LOAD || u_if.pc_target_o !== 32'h200) begin
      n_err++;
      $display("FAIL pri_release_jmp: got %b/%h want %b/%h", ctl(), u_if.pc_target_o, V_LOAD, 32'h200);
    end
    step();
    idle_inputs();
    #1;
    n_cmp++;
    if (ctl() !== V_IDLE) begin
      n_err++;
      $display("FAIL pri_after: got %b want %b", ctl(), V_IDLE);
    end
  endtask

  task automatic test_memwait();
    do_reset();
    u_if.ex_rtltype_i    = RMEM;
    u_if.ex_gprs_waddr_i = 5'd7;
    u_if.id_rs1_i        = 5'd7;
    u_if.mem_busy_i      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (ctl() !== V_BUSY) begin
        n_err++;
        $display("FAIL mw_busy%0d: got %b want %b", i, ctl(), V_BUSY);
      end
      step();
    end
    u_if.mem_busy_i = 1'b0;
    #1;
    n_cmp++;
    if (ctl() !== V_BUBL) begin
      n_err++;
      $display("FAIL mw_lu: got %b want %b", ctl(), V_BUBL);
    end
    step();
    idle_inputs();
    #1;
    n_cmp++;
    if (cnt !== 16'd4) begin
      n_err++;
      $display("FAIL mw_cnt: got %0d want 4", cnt);
    end
  endtask

  task automatic test_halt();
    do_reset();
    u_if.id_error_i = 1'b1;
    #1;
    n_cmp++;
    if (ctl() !== V_BUBL) begin
      n_err++;
      $display("FAIL err_detect: got %b want %b", ctl(), V_BUBL);
    end
    step();
    u_if.id_error_i       = 1'b0;
    u_if.ex_jump_i        = 1'b1;
    u_if.ex_jump_target_i = 32'h0000_0300;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (ctl() !== V_HALT || u_if.pc_target_o !== 32'd0) begin
        n_err++;
        $display("FAIL halt%0d: got %b/%h want %b/0", i, ctl(), u_if.pc_target_o, V_HALT);
      end
      step();
    end
    n_cmp++;
    if (cnt !== 16'd4) begin
      n_err++;
      $display("FAIL halt_cnt: got %0d want 4", cnt);
    end
    idle_inputs();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (ctl() !== V_LOAD) begin
      n_err++;
      $display("FAIL halt_rst: got %b want %b", ctl(), V_LOAD);
    end
    step();
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (ctl() !== V_LOAD || cnt !== 16'd0) begin
      n_err++;
      $display("FAIL halt_boot: got %b/%0d want %b/0", ctl(), cnt, V_LOAD);
    end
    step();
    n_cmp++;
    if (ctl() !== V_IDLE) begin
      n_err++;
      $display("FAIL halt_run: got %b want %b", ctl(), V_IDLE);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    u_if.mem_busy_i = 1'b1;
    for (int i = 0; i < 5; i++) step();
    n_cmp++;
    if (cnt2 !== 2'd3) begin
      n_err++;
      $display("FAIL sat_w2: got %0d want 3", cnt2);
    end
    n_cmp++;
    if (cnt !== 16'd5) begin
      n_err++;
      $display("FAIL sat_w16: got %0d want 5", cnt);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (ctl() !== V_LOAD) begin
      n_err++;
      $display("FAIL mw_rst: got %b want %b", ctl(), V_LOAD);
    end
    step();
    rst_n = 1'b1;
    u_if.mem_busy_i = 1'b0;
    #1;
    n_cmp++;
    if (cnt !== 16'd0 || cnt2 !== 2'd0) begin
      n_err++;
      $display("FAIL mw_rst_cnt: got %0d/%0d want 0/0", cnt, cnt2);
    end
    step();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_load_use();
    test_jump_error();
    test_priority();
    test_memwait();
    test_halt();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
